// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare/branch ops, iterative
// one-bit-per-cycle shifts, valid/ready handshakes on both sides.
module alu_iter_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         operation,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_BGE = 4'b1010;
  localparam logic [3:0] OP_BLT = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_LUI = 4'b1101;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shreg_step;
  logic [WIDTH-1:0]   alu_value;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] shamt;
  logic               sh_left;
  logic               sh_arith;
  logic               is_shift;
  logic               start_shift;
  logic               accept;
  logic               shift_last;
  logic               a_lt_b;

  assign shamt       = src_b[SHAMT_W-1:0];
  assign is_shift    = (operation == OP_SRA) || (operation == OP_SLL) ||
                       (operation == OP_SRL);
  assign start_shift = is_shift && (shamt != '0);
  assign in_ready    = (state == IDLE) && !reset;
  assign accept      = in_valid && in_ready && !flush;
  assign out_valid   = (state == DONE);
  assign shift_last  = (cnt == SHAMT_W'(1));
  assign a_lt_b      = $signed(src_a) < $signed(src_b);

  // Single-cycle result; a shift only lands here when its amount is zero.
  always_comb begin
    alu_value = '0;
    case (operation)
      OP_AND:                 alu_value = src_a & src_b;
      OP_OR:                  alu_value = src_a | src_b;
      OP_ADD:                 alu_value = src_a + src_b;
      OP_SUB:                 alu_value = src_a - src_b;
      OP_XOR:                 alu_value = src_a ^ src_b;
      OP_SRA, OP_SLL, OP_SRL: alu_value = src_a;
      OP_SLT, OP_BLT:         alu_value = {{(WIDTH-1){1'b0}}, a_lt_b};
      OP_BGE:                 alu_value = {{(WIDTH-1){1'b0}}, !a_lt_b};
      OP_BEQ:                 alu_value = {{(WIDTH-1){1'b0}}, src_a == src_b};
      OP_BNE:                 alu_value = {{(WIDTH-1){1'b0}}, src_a != src_b};
      OP_LUI:                 alu_value = src_b;
      default:                alu_value = '0;
    endcase
  end

  always_comb begin
    shreg_step = shreg;
    if (sh_left) begin
      shreg_step = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shreg_step = {sh_arith & shreg[WIDTH-1], shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = start_shift ? SHIFT : DONE;
        SHIFT:   if (shift_last) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Flush leaves result stale on purpose; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b1;
      cnt      <= '0;
      shreg    <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              shreg    <= src_a;
              cnt      <= shamt;
              sh_left  <= (operation == OP_SLL);
              sh_arith <= (operation == OP_SRA);
            end else begin
              result <= alu_value;
              zero   <= (alu_value == '0);
            end
          end
        end
        SHIFT: begin
          shreg <= shreg_step;
          cnt   <= cnt - SHAMT_W'(1);
          if (shift_last) begin
            result <= shreg_step;
            zero   <= (shreg_step == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_iter_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checkCount = 0;
  int failCount  = 0;

  alu_iter_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference model written straight from the opcode table.
  function automatic logic [31:0] refResult(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    int unsigned sh;
    sa = a;
    sb = b;
    sh = b % 32;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return a ^ b;
      4'd5:  return 32'(sa >>> sh);
      4'd6:  return a << sh;
      4'd9:  return a >> sh;
      4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd12: return (a != b) ? 32'd1 : 32'd0;
      4'd11: return (sa < sb) ? 32'd1 : 32'd0;
      4'd10: return (sa >= sb) ? 32'd1 : 32'd0;
      4'd13: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'd5 || op == 4'd6 || op == 4'd9) && (b % 32) != 0)
      return 1 + int'(b % 32);
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for its result, optionally stall the consumer.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int hold);
    logic [31:0] expRes;
    int lat, n;
    expRes = refResult(op, a, b);
    lat    = refLatency(op, b);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    src_a     = $urandom;
    src_b     = $urandom;
    operation = 4'($urandom);
    n = 1;
    while (!out_valid && n <= 40) begin
      if (in_ready) checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
      step();
      n++;
    end
    checkOutput("latency", 32'(n), 32'(lat));
    checkOutput("result", result, expRes);
    checkOutput("zero", 32'(zero), 32'(expRes == 32'd0));
    for (int i = 0; i < hold; i++) begin
      step();
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_result", result, expRes);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("handoff_valid", 32'(out_valid), 32'd0);
    checkOutput("handoff_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen;
    logic [3:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    operation = 4'd0; src_a = 32'd0; src_b = 32'd0;
    step();
    step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd1);
    reset = 1'b0;
    step();

    applyStimulus(4'd2, 32'hFFFFFFFF, 32'h1, 0);
    applyStimulus(4'd9, 32'h80000000, 32'd31, 0);
    applyStimulus(4'd5, 32'h80000000, 32'd4, 0);
    applyStimulus(4'd6, 32'h1, 32'd0, 0);
    applyStimulus(4'd7, 32'hFFFFFFFF, 32'h1, 0);
    applyStimulus(4'd10, 32'hFFFFFFFF, 32'h1, 0);
    applyStimulus(4'd11, 32'hFFFFFFFF, 32'h1, 0);
    applyStimulus(4'd8, 32'h1234, 32'h1234, 0);
    applyStimulus(4'd12, 32'h1234, 32'h1234, 0);
    applyStimulus(4'd13, 32'h0, 32'hABCDE000, 0);
    applyStimulus(4'd4, 32'hF0F0F0F0, 32'hFFFF0000, 3);
    applyStimulus(4'd15, 32'h5, 32'h7, 1);

    // Flush mid-shift: SLL by 10 aborted in its fourth busy cycle.
    operation = 4'd6; src_a = 32'h1; src_b = 32'd10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    checkOutput("flush_no_result", 32'(seen), 32'd0);
    applyStimulus(4'd2, 32'd2, 32'd3, 0);

    // Flush together with in_valid in IDLE must not accept.
    operation = 4'd2; src_a = 32'd9; src_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_noaccept_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_noaccept_ready", 32'(in_ready), 32'd1);

    // Reset while shifting.
    operation = 4'd9; src_a = 32'hDEADBEEF; src_b = 32'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_zero", 32'(zero), 32'd1);
    checkOutput("midrst_in_ready2", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_release", 32'(in_ready), 32'd1);
    step();

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = 32'd0;
      applyStimulus(op, a, b, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
Execute-stage ALU that consumes the 4-bit operation code produced by ALU decode and computes the result.
- Logic, arithmetic, compare and branch-condition operations complete in one cycle.
- Shifts run iteratively, one bit position per cycle, to save area.
- Valid/ready handshakes on both sides let the pipeline hazard logic stall around variable latency.
- Sits between the ID/EX register and the EX/MEM register.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; equals log2(WIDTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  synchronous pipeline flush; aborts in-flight op
in_valid  in  1  op/operands valid
in_ready  out  1  unit can accept an op
operation  in  4  operation code
src_a  in  WIDTH  operand A (rs1)
src_b  in  WIDTH  operand B (rs2/imm); shift amount = src_b[SHAMT_W-1:0]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  WIDTH  result; branch ops give 1 = condition true, else 0
zero  out  1  result == 0

Behaviour:
Clock and reset:
- One clock domain: clk.
- reset is synchronous, active-high.
- Reset values: state IDLE, out_valid 0, result 0, zero 1, shift counter 0.
- in_ready is 0 while reset is asserted.

Operation codes (signed = two's complement):
- 0000 AND; 0001 OR; 0010 ADD; 0011 SUB; 0100 XOR.
- 0101 SRA (iterative); 0110 SLL (iterative); 1001 SRL (iterative).
- 0111 SLT (signed, result 1/0).
- 1000 BEQ (a==b); 1100 BNE (a!=b); 1011 BLT (signed a<b); 1010 BGE (signed a>=b).
- 1101 LUI (result = src_b).
- 1110 and 1111: result 0, single-cycle.

Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no overflow flag.

FSM states IDLE, SHIFT, DONE:
- in_ready = (state == IDLE) and not reset. Accept = in_valid and in_ready. Operation and operands are sampled only on accept.
- IDLE, accept of a non-shift op or a shift with shamt 0: result registered, go to DONE. out_valid is high the cycle after accept (latency 1).
- IDLE, accept of a shift with shamt > 0: latch src_a into the shift register, counter = shamt, latch direction/arith, go to SHIFT.
- SHIFT, each cycle:
  - shift by one bit (SLL fills 0; SRL fills 0; SRA replicates the MSB) and decrement the counter.
  - when the counter is 1 this cycle, go to DONE.
- Shift latency: accept at cycle T gives out_valid at T+1+shamt (max T+32 for WIDTH 32).
- DONE: out_valid = 1; result and zero are held stable.
  - out_ready = 1: go to IDLE; in_ready is high the next cycle.
  - No same-cycle result hand-off plus new accept. Maximum throughput is one op per 2 cycles.
  - out_ready low: remain in DONE indefinitely with result unchanged.
- Inputs arriving while not in IDLE are ignored; the upstream stage must hold them until in_ready.

Priority and corner cases:
- Priority: reset > flush > normal operation.
- flush in any state: next state IDLE, out_valid 0, counter 0. result keeps its stale value, but consumers must qualify it with out_valid.
- flush together with in_valid in IDLE: no accept.
- zero tracks the registered result.

Test Plan:
- ADD: a=0xFFFFFFFF, b=0x00000001 -> result 0x00000000, zero 1, out_valid exactly 1 cycle after accept.
- SRL: a=0x80000000, b=31 -> result 0x00000001 at T+32; in_ready low T+1..T+32. SRA: a=0x80000000, b=4 -> 0xF8000000 at T+5. SLL: a=0x1, b=0 -> 0x1 at T+1.
- Signed compares: SLT a=0xFFFFFFFF, b=0x1 -> 1; BGE same operands -> 0; BLT -> 1; BEQ a=b=0x1234 -> 1; BNE same operands -> 0; LUI b=0xABCDE000 -> 0xABCDE000.
- Backpressure: XOR a=0xF0F0F0F0, b=0xFFFF0000 with out_ready low 3 cycles -> out_valid and result 0x0F0FF0F0 stable for all 3 cycles; in_ready stays low; IDLE the cycle after out_ready rises.
- Flush mid-shift: SLL shamt=10, flush at T+4 -> out_valid never rises for that op; in_ready 1 at T+5. A following ADD 2+3 -> result 5 at its T+1.
- Reset mid-op: assert reset during SHIFT -> out_valid 0, zero 1, result 0, in_ready 0 during reset, 1 after release.
